nf10_axis_rx_tagger: RTL
========================

// Module: nf10_axis_rx_tagger
// PURPOSE
//  Parametrised store-and-forward receive stage between a 10G MAC AXI-Stream output and the datapath.
//  Buffers whole packets, counts bytes, and emits each packet with NetFPGA tuser metadata on the first beat.
//  Packets that cannot be fully buffered are dropped atomically; no partial packet ever leaves the block.
//  Generalises the fixed 64-bit, default-port-only interface: any data width, configurable depth, drop handling.
// PARAMETERS
//  C_AXIS_DATA_WIDTH   64      tdata width; 64, 128 or 256; tstrb width = C_AXIS_DATA_WIDTH/8
//  C_AXIS_TUSER_WIDTH  128     tuser width; must be >= 32
//  C_FIFO_DEPTH_BITS   9       data FIFO holds 2**N beats
//  C_META_DEPTH_BITS   4       metadata FIFO holds 2**N packets
//  C_SRC_PORT          8'h01   one-hot source port written to tuser[23:16]
//  C_DST_PORT          8'h00   destination port written to tuser[31:24]
// PORTS
//  axi_aclk       in   1      single clock; all logic is rising-edge
//  axi_resetn     in   1      asynchronous assert, active-low reset
//  s_axis_tdata   in   DW     MAC receive data
//  s_axis_tstrb   in   DW/8   byte enables; contiguous from bit 0
//  s_axis_tvalid  in   1      input beat valid
//  s_axis_tready  out  1      input ready
//  s_axis_tlast   in   1      last beat of packet
//  m_axis_tdata   out  DW     buffered data
//  m_axis_tstrb   out  DW/8   buffered byte enables
//  m_axis_tuser   out  TUW    metadata; nonzero only on the first beat
//  m_axis_tvalid  out  1      output beat valid
//  m_axis_tready  in   1      downstream ready
//  m_axis_tlast   out  1      last beat of packet
// BEHAVIOUR
//  - Reset: all m_axis_* = 0, s_axis_tready = 0, FIFOs empty, both FSMs in IDLE.
//    s_axis_tready = 1 from the first clock edge after axi_resetn deasserts.
//  - s_axis_tready is 1 at all times outside reset. Overflow is handled by dropping, never by back-pressure.
//  - Write FSM
//    - IDLE: on the first beat, go to DROP if the meta FIFO is full. Otherwise write the beat, start len = popcount(tstrb), go to WRITE.
//    - WRITE: each beat adds popcount(tstrb) to len. len is 16 bits and saturates at 16'hFFFF.
//    - WRITE, data FIFO full when a beat arrives: rewind wr_ptr to the start-of-packet pointer and go to DROP.
//    - WRITE, tlast beat written: commit wr_ptr, push {C_DST_PORT, C_SRC_PORT, len} to the meta FIFO, go to IDLE.
//    - DROP: discard beats until tlast, then go to IDLE. The dropped packet leaves no trace in either FIFO.
//    - A single-beat packet (tlast on the first beat) goes IDLE -> commit in one cycle.
//  - Full/empty: 1-bit-extended pointers. Full when wr - rd == 2**N. The read side sees only committed wr_ptr.
//  - Read FSM
//    - IDLE: when the meta FIFO is non-empty, pop the meta entry and go to SEND.
//    - SEND: present beats from the data FIFO. tuser[31:0] = meta on the first beat; upper tuser bits are always 0.
//    - SEND: the beat with stored tlast, once accepted, returns the FSM to IDLE.
//  - Latency: the first output beat has tvalid = 1 exactly 2 cycles after the input tlast beat is accepted, when both FIFOs were empty.
//  - Output handshake
//    - Standard AXI-Stream: while tvalid = 1 and tready = 0, all m_axis_* hold stable.
//    - Back-to-back packets: no idle cycle between one packet's tlast and the next packet's first beat.
//  - Simultaneous commit and read in the same cycle are both honoured. Pointers wrap modulo 2**N.
//  - Reset mid-packet: any partial or stored packets are discarded. Outputs return to reset values immediately (async).
// CONFIGURATION
//  NF10_RX_TAGGER_STATS_EN
//  - Defined: adds outputs pkt_cnt_o[31:0] and drop_cnt_o[31:0].
//    - pkt_cnt_o increments on each meta push; drop_cnt_o increments on each entry to DROP.
//    - Both are wrapping counters, reset to 0.
//  - Undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING  (DW=64, C_FIFO_DEPTH_BITS=4, C_META_DEPTH_BITS=2, SRC=8'h01, DST=8'h00)
//  1. Single packet: 3 beats, tstrb FF,FF,0F -> 3 beats out, data in order, tuser[31:0]=32'h0001_0014 on beat 1, 0 on beats 2-3, tvalid 2 cycles after input tlast.
//  2. Data overflow: 20-beat packet -> no output and drop_cnt_o=1. A following 2-beat packet (FF,FF) -> tuser[15:0]=16, pkt_cnt_o=1.
//  3. Back-pressure: m_axis_tready=0 for 12 cycles while two 2-beat packets arrive -> both emerge in order, outputs stable during the stall, no gap between packets.
//  4. Meta full: m_axis_tready=0, five 1-beat packets -> first four delivered when tready rises, fifth dropped, drop_cnt_o=1.
//  5. Reset mid-packet: assert axi_resetn=0 on beat 2 of 4 -> m_axis_tvalid=0 at once, nothing emitted after release, next packet passes normally.
//  6. Concurrent: stream 1-beat packets every cycle with tready=1 -> steady 1 packet/cycle out, no drops, counters equal.

Source files
------------

// File: rtl/nf10_axis_rx_tagger.sv
// nf10_axis_rx_tagger: store-and-forward receive stage for a 10G MAC AXI-Stream.
// Whole packets are buffered, their byte count is measured, and each packet is
// replayed with NetFPGA tuser metadata on its first beat. Packets that do not fit
// are dropped atomically.
// Optional statistics outputs pkt_cnt_o / drop_cnt_o: define NF10_RX_TAGGER_STATS_EN.
module nf10_axis_rx_tagger #(
  parameter int         C_AXIS_DATA_WIDTH  = 64,
  parameter int         C_AXIS_TUSER_WIDTH = 128,
  parameter int         C_FIFO_DEPTH_BITS  = 9,
  parameter int         C_META_DEPTH_BITS  = 4,
  parameter logic [7:0] C_SRC_PORT         = 8'h01,
  parameter logic [7:0] C_DST_PORT         = 8'h00
) (
  input  logic                            axi_aclk,
  input  logic                            axi_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
`ifdef NF10_RX_TAGGER_STATS_EN
  ,
  output logic [31:0]                     pkt_cnt_o,
  output logic [31:0]                     drop_cnt_o
`endif
);

  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int FB = C_FIFO_DEPTH_BITS;
  localparam int MB = C_META_DEPTH_BITS;
  localparam int FD = 1 << FB;
  localparam int MD = 1 << MB;

  localparam logic [FB:0] DATA_FULL_GAP = {1'b1, {FB{1'b0}}};
  localparam logic [MB:0] META_FULL_GAP = {1'b1, {MB{1'b0}}};

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DROP} wr_state_t;
  typedef enum logic       {R_IDLE, R_SEND}          rd_state_t;

  // Storage arrays (no reset needed; validity is tracked by the pointers)
  logic [C_AXIS_DATA_WIDTH-1:0] d_data   [FD];
  logic [SW-1:0]                d_strb   [FD];
  logic                         d_last   [FD];
  logic [31:0]                  meta_mem [MD];

  // Data FIFO pointers: wr_ptr is speculative, wr_commit is what the reader sees
  logic [FB:0] wr_ptr, wr_sop, wr_commit, rd_ptr;
  // Meta FIFO pointers: a slot stays occupied until its packet's tlast is accepted
  logic [MB:0] meta_wr, meta_fetch, meta_free;

  wr_state_t w_state;
  logic [15:0] len;
  rd_state_t r_state;
  logic [31:0] cur_meta;
  logic        first_beat;

  logic        in_fire, data_full, meta_full;
  logic        data_we, meta_we, drop_start;
  logic [15:0] len_base, beat_len;
  logic [16:0] len_sum;
  logic        data_avail, meta_avail, can_load;
  logic [C_AXIS_TUSER_WIDTH-1:0] first_tuser;

  function automatic logic [15:0] popcount(input logic [SW-1:0] v);
    logic [15:0] n;
    n = '0;
    for (int unsigned i = 0; i < SW; i++) n = n + 16'(v[i]);
    return n;
  endfunction

  // Write-side decisions: what to do with the beat presented this cycle
  always_comb begin
    in_fire    = s_axis_tvalid & s_axis_tready;
    data_full  = (wr_ptr - rd_ptr) == DATA_FULL_GAP;
    meta_full  = (meta_wr - meta_free) == META_FULL_GAP;
    len_base   = (w_state == W_WRITE) ? len : '0;
    len_sum    = {1'b0, len_base} + {1'b0, popcount(s_axis_tstrb)};
    beat_len   = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    data_we    = 1'b0;
    meta_we    = 1'b0;
    drop_start = 1'b0;
    if (in_fire) begin
      case (w_state)
        W_IDLE: begin
          if (meta_full || data_full) drop_start = 1'b1;
          else begin
            data_we = 1'b1;
            meta_we = s_axis_tlast;
          end
        end
        W_WRITE: begin
          if (data_full) drop_start = 1'b1;
          else begin
            data_we = 1'b1;
            meta_we = s_axis_tlast;
          end
        end
        default: ;
      endcase
    end
  end

  // Read-side status and the metadata image placed on the first output beat
  always_comb begin
    data_avail        = rd_ptr != wr_commit;
    meta_avail        = meta_wr != meta_fetch;
    can_load          = !m_axis_tvalid || m_axis_tready;
    first_tuser       = '0;
    first_tuser[31:0] = cur_meta;
  end

  // FIFO storage writes
  always_ff @(posedge axi_aclk) begin
    if (data_we) begin
      d_data[wr_ptr[FB-1:0]] <= s_axis_tdata;
      d_strb[wr_ptr[FB-1:0]] <= s_axis_tstrb;
      d_last[wr_ptr[FB-1:0]] <= s_axis_tlast;
    end
    if (meta_we) meta_mem[meta_wr[MB-1:0]] <= {C_DST_PORT, C_SRC_PORT, beat_len};
  end

  // Write FSM: buffer, count, commit or rewind-and-drop
  // A dropped beat that is itself tlast ends the drop immediately, so the
  // next packet's first beat is never swallowed by the DROP state.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      s_axis_tready <= 1'b0;
      w_state       <= W_IDLE;
      wr_ptr        <= '0;
      wr_sop        <= '0;
      wr_commit     <= '0;
      meta_wr       <= '0;
      len           <= '0;
    end else begin
      s_axis_tready <= 1'b1;
      case (w_state)
        W_IDLE, W_WRITE: begin
          if (drop_start) begin
            wr_ptr  <= wr_sop;
            w_state <= s_axis_tlast ? W_IDLE : W_DROP;
          end else if (data_we) begin
            wr_ptr <= wr_ptr + 1'b1;
            len    <= beat_len;
            if (meta_we) begin
              wr_commit <= wr_ptr + 1'b1;
              wr_sop    <= wr_ptr + 1'b1;
              meta_wr   <= meta_wr + 1'b1;
              w_state   <= W_IDLE;
            end else begin
              w_state <= W_WRITE;
            end
          end
        end
        W_DROP: if (in_fire && s_axis_tlast) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: fetch metadata, then stream the packet through the output register
  // When the tlast beat is loaded and another packet is ready, its metadata is
  // fetched in the same cycle so consecutive packets leave without a gap.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state       <= R_IDLE;
      rd_ptr        <= '0;
      meta_fetch    <= '0;
      meta_free     <= '0;
      cur_meta      <= '0;
      first_beat    <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) meta_free <= meta_free + 1'b1;
      if (can_load && !(r_state == R_SEND && data_avail)) begin
        m_axis_tdata  <= '0;
        m_axis_tstrb  <= '0;
        m_axis_tuser  <= '0;
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
      case (r_state)
        R_IDLE: begin
          if (meta_avail) begin
            cur_meta   <= meta_mem[meta_fetch[MB-1:0]];
            meta_fetch <= meta_fetch + 1'b1;
            first_beat <= 1'b1;
            r_state    <= R_SEND;
          end
        end
        R_SEND: begin
          if (can_load && data_avail) begin
            m_axis_tdata  <= d_data[rd_ptr[FB-1:0]];
            m_axis_tstrb  <= d_strb[rd_ptr[FB-1:0]];
            m_axis_tlast  <= d_last[rd_ptr[FB-1:0]];
            m_axis_tvalid <= 1'b1;
            m_axis_tuser  <= first_beat ? first_tuser : '0;
            rd_ptr        <= rd_ptr + 1'b1;
            first_beat    <= 1'b0;
            if (d_last[rd_ptr[FB-1:0]]) begin
              if (meta_avail) begin
                cur_meta   <= meta_mem[meta_fetch[MB-1:0]];
                meta_fetch <= meta_fetch + 1'b1;
                first_beat <= 1'b1;
              end else begin
                r_state <= R_IDLE;
              end
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef NF10_RX_TAGGER_STATS_EN
  // Packet and drop statistics (wrapping)
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      pkt_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (meta_we)    pkt_cnt_o  <= pkt_cnt_o + 1'b1;
      if (drop_start) drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end
`endif

endmodule
